// File: rtl/rom_byte_streamer.sv
// Streams every word of the coefficient ROM as bytes, MSB byte first, over valid/ready.
// Fetch is strictly sequential: one address issue, one capture, then the word's bytes.
module rom_byte_streamer #(
  parameter int NUM_WORDS = 9,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              byte_last,
  output logic              frame_last,
  output logic [ADDR_W-1:0] word_idx,
  output logic              busy,
  output logic              done
);
  localparam int NB   = DATA_W / 8;
  localparam int CW   = $clog2(NB + 1);

  localparam logic [CW-1:0]     PEN   = CW'(NB - 2);
  localparam logic [ADDR_W-1:0] LASTW = ADDR_W'(NUM_WORDS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] SHIFT   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;

  assign byte_data = shreg[DATA_W-1 -: 8];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      rom_address <= '0;
      word_idx    <= '0;
      byte_valid  <= 1'b0;
      byte_last   <= 1'b0;
      frame_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            rom_address <= '0;
            word_idx    <= '0;
            busy        <= 1'b1;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          shreg      <= rom_q;
          cnt        <= '0;
          byte_valid <= 1'b1;
          byte_last  <= (NB == 1);
          frame_last <= (NB == 1) && (word_idx == LASTW);
          state      <= SHIFT;
        end
        SHIFT: begin
          if (byte_valid && byte_ready) begin
            shreg <= shreg << 8;
            cnt   <= cnt + 1'b1;
            if (frame_last) begin
              byte_valid <= 1'b0;
              byte_last  <= 1'b0;
              frame_last <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else if (byte_last) begin
              byte_valid  <= 1'b0;
              byte_last   <= 1'b0;
              rom_address <= rom_address + 1'b1;
              word_idx    <= word_idx + 1'b1;
              state       <= ISSUE;
            end else begin
              // flags are registered, so look one byte ahead
              byte_last  <= (cnt == PEN);
              frame_last <= (cnt == PEN) && (word_idx == LASTW);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_byte_streamer.sv
// Directed bench for rom_byte_streamer with a registered-read ROM model.
module tb_rom_byte_streamer;
  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rom_address;
  logic [63:0] rom_q;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        frame_last;
  logic [4:0]  word_idx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [63:0] rom [32];

  rom_byte_streamer #(.NUM_WORDS(9), .ADDR_W(5), .DATA_W(64)) dut (
    .clock(clock), .rst(rst), .start(start), .rom_address(rom_address), .rom_q(rom_q),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .frame_last(frame_last), .word_idx(word_idx),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom[rom_address];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // word k byte j (0-based) is {k, j+1}
  function automatic logic [7:0] exp_byte(input int n);
    return 8'((n / 8) * 16 + (n % 8) + 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, rom_address, 0);
    chk({tag, "_valid"}, byte_valid, 0);
    chk({tag, "_data"}, byte_data, 0);
    chk({tag, "_blast"}, byte_last, 0);
    chk({tag, "_flast"}, frame_last, 0);
    chk({tag, "_widx"}, word_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_stream(input int bp_n, input int bp_len, input bit rnd,
                            input int busy_start_e, input bit done_start, output int last_out);
    int n, stalls, bp_used, last_e;
    bit busy_ok, addr_ok;
    n = 0; stalls = 0; bp_used = 0; last_e = -1; busy_ok = 1; addr_ok = 1;
    start = 1; byte_ready = 1;
    @(posedge clock); #1; start = 0;
    chk("busy_e0", busy, 1);
    for (int e = 1; e < 400 && last_e < 0; e++) begin
      start = (e == busy_start_e);
      if (rnd) byte_ready = 1'($urandom_range(0, 1));
      else if (byte_valid && n == bp_n && bp_used < bp_len) begin
        byte_ready = 0; bp_used++;
      end else byte_ready = 1;
      if (!busy) busy_ok = 0;
      if (rom_address > 8 || int'(rom_address) != n / 8 || int'(word_idx) != n / 8) addr_ok = 0;
      if (byte_valid && !byte_ready) begin
        stalls++;
        chk("hold_data", byte_data, exp_byte(n));
      end
      if (byte_valid && byte_ready) begin
        chk("byte", byte_data, exp_byte(n));
        chk("blast", byte_last, (n % 8) == 7);
        chk("flast", frame_last, n == 71);
        n++;
        if (n == 72) last_e = e;
      end
      @(posedge clock); #1;
    end
    start = 0; byte_ready = 1;
    chk("bytes_n", n, 72);
    chk("last_edge", last_e, 90 + stalls);
    chk("busy_held", busy_ok, 1);
    chk("addr_stable", addr_ok, 1);
    chk("done_hi", done, 1);
    chk("busy_lo", busy, 0);
    chk("valid_lo", byte_valid, 0);
    if (done_start) start = 1;
    @(posedge clock); #1; start = 0;
    chk("done_lo", done, 0);
    chk("idle_busy", busy, 0);
    @(posedge clock); #1;
    chk("no_restart", busy, 0);
    last_out = last_e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    bit done_seen;
    int n;
    for (int k = 0; k < 32; k++) begin
      rom[k] = '0;
      if (k < 9)
        for (int j = 0; j < 8; j++) rom[k][63 - 8*j -: 8] = 8'(k * 16 + j + 1);
    end
    rst = 1; start = 0; byte_ready = 1;
    repeat (3) @(posedge clock);
    #1; chk_all_zero("reset");
    rst = 0;
    @(posedge clock); #1;
    chk("idle_busy0", busy, 0);

    run_stream(-1, 0, 0, -1, 0, last);
    chk("full_last_e90", last, 90);

    run_stream(10, 5, 0, -1, 0, last);
    chk("bp_last_e95", last, 95);

    run_stream(-1, 0, 1, -1, 0, last);

    run_stream(-1, 0, 0, 30, 1, last);
    chk("busy_start_e90", last, 90);
    run_stream(-1, 0, 0, -1, 0, last);
    chk("restart_e90", last, 90);

    // abandon a frame at word 3 byte 4
    start = 1; byte_ready = 1;
    @(posedge clock); #1; start = 0;
    n = 0;
    for (int e = 1; e < 200 && !(byte_valid && n == 28); e++) begin
      if (byte_valid) n++;
      @(posedge clock); #1;
    end
    chk("pre_rst_data", byte_data, 8'h35);
    #2 rst = 1;
    #1 chk_all_zero("async_rst");
    done_seen = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done) done_seen = 1;
    end
    rst = 0;
    @(posedge clock); #1;
    if (done) done_seen = 1;
    chk("rst_no_done", done_seen, 0);
    chk("rst_busy0", busy, 0);
    run_stream(-1, 0, 0, -1, 0, last);
    chk("post_rst_e90", last, 90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
